// File: rtl/eh2_lsu_trigger_chain_if.sv
// DC3 request bundle fed into the LSU trigger unit.
// The master drives a load/store packet and the trigger unit consumes it.
interface eh2_lsu_trigger_chain_if #(
    parameter int DW   = 32,
    parameter int TIDW = 1
);
    logic            valid;
    logic            load;
    logic            store;
    logic            atomic;
    logic            dma;
    logic [TIDW-1:0] tid;
    logic [1:0]      size;
    logic [DW-1:0]   addr;
    logic [DW-1:0]   store_data;
    logic [DW-1:0]   amo_data;

    modport master (
        output valid, load, store, atomic, dma,
        output tid, size, addr, store_data, amo_data
    );

    modport slave (
        input valid, load, store, atomic, dma,
        input tid, size, addr, store_data, amo_data
    );
endinterface

// File: rtl/eh2_lsu_trigger_chain.sv
// LSU data/address trigger unit with a private DC4 stage, pairwise chaining,
// hit-count thresholds and sticky per-thread hit status.
module eh2_lsu_trigger_chain #(
    parameter int NUM_THREADS = 2,
    parameter int NUM_TRIG    = 4,
    parameter int DW          = 32,
    parameter int CNT_W       = 8,
    localparam int TIDW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int NTT  = NUM_THREADS * NUM_TRIG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NTT-1:0]          cfg_select,
    input  logic [NTT-1:0]          cfg_load,
    input  logic [NTT-1:0]          cfg_store,
    input  logic [NTT-1:0]          cfg_napot,
    input  logic [NTT-1:0]          cfg_chain,
    input  logic [NTT*DW-1:0]       cfg_tdata2,
    input  logic [NTT*CNT_W-1:0]    cfg_count,
    input  logic [NUM_THREADS-1:0]  cfg_wr,
    eh2_lsu_trigger_chain_if.slave  dc3,
    input  logic [NUM_THREADS-1:0]  flush_dc4,
    input  logic [NTT-1:0]          status_clr,
    output logic [NUM_TRIG-1:0]     match_dc4,
    output logic [TIDW-1:0]         match_tid_dc4,
    output logic [NTT-1:0]          hit_status
);

    logic             valid4, load4, store4, dma4;
    logic [TIDW-1:0]  tid4;
    logic [DW-1:0]    addr4, sdata4, sdata3, smask;
    logic [CNT_W-1:0] cnt [NTT];
    logic [CNT_W-1:0] nxt [NTT];
    logic [NTT-1:0]   upd, st_set;
    logic [NUM_TRIG-1:0] q, h, fire;
    logic [CNT_W:0]   se, so;
    logic             ch;
    int               base;

    // Masked compare: the trailing ones of tdata2 plus the first zero are don't-care
    function automatic logic cmp_hit(input logic [DW-1:0] d,
                                     input logic [DW-1:0] t2,
                                     input logic          napot);
        logic [DW-1:0] dc;
        dc = napot ? (t2 ^ (t2 + DW'(1))) : '0;
        return ((d ^ t2) & ~dc) == '0;
    endfunction

    // Returns {wrap, next count}; wrap means this hit reaches the threshold
    function automatic logic [CNT_W:0] step(input logic [CNT_W-1:0] c,
                                            input logic [CNT_W-1:0] n);
        logic wrap;
        wrap = (n <= CNT_W'(1)) || (c >= n - CNT_W'(1));
        return {wrap, wrap ? {CNT_W{1'b0}} : c + CNT_W'(1)};
    endfunction

    always_comb begin
        unique case (dc3.size)
            2'b00:   smask = DW'(8'hff);
            2'b01:   smask = DW'(16'hffff);
            default: smask = '1;
        endcase
        sdata3 = (dc3.atomic ? dc3.amo_data : dc3.store_data) & smask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid4 <= 1'b0;
            load4  <= 1'b0;
            store4 <= 1'b0;
            dma4   <= 1'b0;
            tid4   <= '0;
            addr4  <= '0;
            sdata4 <= '0;
        end else begin
            valid4 <= dc3.valid;
            load4  <= dc3.load;
            store4 <= dc3.store;
            dma4   <= dc3.dma;
            tid4   <= dc3.tid;
            addr4  <= dc3.addr;
            sdata4 <= sdata3;
        end
    end

    always_comb begin
        base   = int'(tid4) * NUM_TRIG;
        q      = '0;
        h      = '0;
        fire   = '0;
        upd    = '0;
        st_set = '0;
        se     = '0;
        so     = '0;
        ch     = 1'b0;
        for (int j = 0; j < NTT; j++) nxt[j] = cnt[j];

        for (int i = 0; i < NUM_TRIG; i++) begin
            q[i] = valid4 & ~dma4 & ~flush_dc4[tid4]
                 & cmp_hit(cfg_select[base+i] ?
                               (store4 ? sdata4 : {DW{1'b0}}) : addr4,
                           cfg_tdata2[(base+i)*DW +: DW],
                           cfg_napot[base+i])
                 & ((cfg_store[base+i] & store4)
                   | (cfg_load[base+i] & load4 & ~store4
                      & ~cfg_select[base+i]));
        end

        // A chained pair shares the even trigger's counter and fires as one
        for (int p = 0; p < NUM_TRIG / 2; p++) begin
            ch = cfg_chain[base+2*p];
            se = step(cnt[base+2*p], cfg_count[(base+2*p)*CNT_W +: CNT_W]);
            so = step(cnt[base+2*p+1],
                      cfg_count[(base+2*p+1)*CNT_W +: CNT_W]);
            h[2*p]   = ch ? (q[2*p] & q[2*p+1]) : q[2*p];
            h[2*p+1] = ch ? (q[2*p] & q[2*p+1]) : q[2*p+1];
            fire[2*p] = h[2*p] & se[CNT_W] & ~cfg_wr[tid4];
            fire[2*p+1] = ch ? fire[2*p]
                             : (h[2*p+1] & so[CNT_W] & ~cfg_wr[tid4]);
            upd[base+2*p]   = h[2*p];
            nxt[base+2*p]   = se[CNT_W-1:0];
            upd[base+2*p+1] = h[2*p+1] & ~ch;
            nxt[base+2*p+1] = so[CNT_W-1:0];
        end

        for (int i = 0; i < NUM_TRIG; i++) st_set[base+i] = fire[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NTT; j++) cnt[j] <= '0;
            hit_status <= '0;
        end else begin
            for (int j = 0; j < NTT; j++) begin
                if (cfg_wr[j/NUM_TRIG]) cnt[j] <= '0;
                else if (upd[j])        cnt[j] <= nxt[j];
                hit_status[j] <= st_set[j] | (hit_status[j] & ~status_clr[j]);
            end
        end
    end

    assign match_dc4     = fire;
    assign match_tid_dc4 = valid4 ? tid4 : '0;

endmodule

// File: tb/tb_eh2_lsu_trigger_chain.sv
// Directed bench for the LSU trigger unit: a vector table for single
// accesses plus hand sequences for chaining, counting, flush and reset.
module tb_eh2_lsu_trigger_chain;
    localparam int NT = 2;
    localparam int NG = 4;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NT*NG-1:0]    cfg_select, cfg_load, cfg_store, cfg_napot, cfg_chain;
    logic [NT*NG*DW-1:0] cfg_tdata2;
    logic [NT*NG*CW-1:0] cfg_count;
    logic [NT-1:0]       cfg_wr, flush_dc4;
    logic [NT*NG-1:0]    status_clr, hit_status;
    logic [NG-1:0]       match_dc4;
    logic [TW-1:0]       match_tid_dc4;

    eh2_lsu_trigger_chain_if #(.DW(DW), .TIDW(TW)) dc3_bus ();

    eh2_lsu_trigger_chain #(
        .NUM_THREADS(NT), .NUM_TRIG(NG), .DW(DW), .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_select    (cfg_select),
        .cfg_load      (cfg_load),
        .cfg_store     (cfg_store),
        .cfg_napot     (cfg_napot),
        .cfg_chain     (cfg_chain),
        .cfg_tdata2    (cfg_tdata2),
        .cfg_count     (cfg_count),
        .cfg_wr        (cfg_wr),
        .dc3           (dc3_bus),
        .flush_dc4     (flush_dc4),
        .status_clr    (status_clr),
        .match_dc4     (match_dc4),
        .match_tid_dc4 (match_tid_dc4),
        .hit_status    (hit_status)
    );

    typedef struct {
        logic          valid, load, store, atomic, dma;
        logic [TW-1:0] tid;
        logic [1:0]    size;
        logic [DW-1:0] addr, sdata, amo;
        logic [1:0]    flush;
        logic [NG-1:0] em;
        logic [TW-1:0] et;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t tbl [13];
    logic [7:0] cexp;

    function automatic vec_t mk(input logic v, ld, st, at, dm,
                                input logic [TW-1:0] tid,
                                input logic [1:0] sz,
                                input logic [DW-1:0] ad, sd, am,
                                input logic [1:0] fl,
                                input logic [NG-1:0] em,
                                input logic [TW-1:0] et);
        vec_t r;
        r.valid = v;  r.load = ld; r.store = st; r.atomic = at; r.dma = dm;
        r.tid = tid;  r.size = sz; r.addr = ad;  r.sdata = sd;  r.amo = am;
        r.flush = fl; r.em = em;   r.et = et;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_trig(input int t, input int i,
                            input logic sel, ld, st, np, chn,
                            input logic [DW-1:0] td,
                            input logic [CW-1:0] cn);
        int x;
        x = t * NG + i;
        cfg_select[x] = sel;
        cfg_load[x]   = ld;
        cfg_store[x]  = st;
        cfg_napot[x]  = np;
        cfg_chain[x]  = chn;
        cfg_tdata2[x*DW +: DW] = td;
        cfg_count[x*CW +: CW]  = cn;
    endtask

    task automatic drive(input vec_t v);
        dc3_bus.valid      = v.valid;
        dc3_bus.load       = v.load;
        dc3_bus.store      = v.store;
        dc3_bus.atomic     = v.atomic;
        dc3_bus.dma        = v.dma;
        dc3_bus.tid        = v.tid;
        dc3_bus.size       = v.size;
        dc3_bus.addr       = v.addr;
        dc3_bus.store_data = v.sdata;
        dc3_bus.amo_data   = v.amo;
    endtask

    task automatic apply(input string nm, input vec_t v,
                         input logic [NT*NG-1:0] clr);
        @(negedge clk);
        drive(v);
        @(negedge clk);
        flush_dc4  = v.flush;
        status_clr = clr;
        #1;
        chk({nm, "_match"}, match_dc4, v.em);
        chk({nm, "_tid"}, match_tid_dc4, v.et);
        dc3_bus.valid = 1'b0;
        @(posedge clk);
        #1;
        flush_dc4  = '0;
        status_clr = '0;
    endtask

    initial begin
        vec_t idle, st80;
        rst = 1'b1;
        cfg_select = '0; cfg_load = '0; cfg_store = '0;
        cfg_napot = '0;  cfg_chain = '0;
        cfg_tdata2 = '0; cfg_count = '0; cfg_wr = '0;
        flush_dc4 = '0;  status_clr = '0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0);
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_match", match_dc4, 0);
        chk("reset_tid", match_tid_dc4, 0);
        chk("reset_status", hit_status, 0);

        set_trig(0, 0, 0, 0, 1, 0, 0, 'h1000, 0);
        set_trig(0, 1, 0, 1, 0, 1, 0, 'h2007, 0);
        set_trig(0, 2, 1, 1, 0, 1, 0, 'hffffffff, 0);
        set_trig(1, 2, 1, 0, 1, 0, 0, 'h1234, 0);

        tbl[0]  = mk(1, 0, 1, 0, 0, 0, 2, 'h1000, 'hdeadbeef, 0, 0, 'b0001, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 1, 1, 'h0, 'habcd1234, 0, 0, 'b0100, 1);
        tbl[2]  = mk(1, 0, 1, 0, 0, 1, 0, 'h0, 'habcd1234, 0, 0, 'b0000, 1);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 2, 'h2000, 0, 0, 0, 'b0010, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 0, 2, 'h200f, 0, 0, 0, 'b0010, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 0, 2, 'h2010, 0, 0, 0, 'b0000, 0);
        tbl[6]  = mk(1, 0, 1, 1, 0, 1, 2, 'h0, 'habcd1234, 'h1234, 0, 'b0100, 1);
        tbl[7]  = mk(1, 0, 1, 0, 1, 0, 2, 'h1000, 0, 0, 0, 'b0000, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0, 0, 2, 'h1000, 0, 0, 'b01, 'b0000, 0);
        tbl[9]  = mk(1, 0, 1, 0, 0, 0, 2, 'h1000, 0, 0, 'b10, 'b0001, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 2, 'h1000, 0, 0, 0, 'b0000, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 1, 2, 'h1000, 0, 0, 0, 'b0000, 1);
        tbl[12] = mk(1, 0, 1, 0, 0, 0, 2, 'h1001, 0, 0, 0, 'b0000, 0);
        for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i], '0);
        chk("status_after_table", hit_status, 'h43);

        apply("clr_all", idle, '1);
        chk("status_cleared", hit_status, 0);

        // chained pair: address on trigger 0, store data on trigger 1
        set_trig(0, 0, 0, 0, 1, 0, 1, 'h40, 0);
        set_trig(0, 1, 1, 0, 1, 0, 0, 'h5, 0);
        apply("chain_both", mk(1, 0, 1, 0, 0, 0, 2, 'h40, 5, 0, 0, 'b0011, 0), '0);
        apply("chain_data", mk(1, 0, 1, 0, 0, 0, 2, 'h40, 6, 0, 0, 'b0000, 0), '0);
        apply("chain_addr", mk(1, 0, 1, 0, 0, 0, 2, 'h44, 5, 0, 0, 'b0000, 0), '0);
        chk("status_chain", hit_status, 'h03);

        // threshold 3, back-to-back hits, config write lands on hit 5
        set_trig(0, 3, 0, 0, 1, 0, 0, 'h80, 3);
        st80 = mk(1, 0, 1, 0, 0, 0, 2, 'h80, 0, 0, 0, 'b0000, 0);
        cexp = 8'b1000_0100;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            cfg_wr = (k == 5) ? 2'b01 : 2'b00;
            if (k > 0) begin
                #1;
                chk($sformatf("count_hit%0d", k), match_dc4,
                    cexp[k-1] ? 4'b1000 : 4'b0000);
            end
            drive(st80);
            dc3_bus.valid = (k < 8);
        end
        @(negedge clk);
        cfg_wr = '0;

        // threshold 2: flushed and DMA hits must not advance the counter
        set_trig(0, 3, 0, 0, 1, 0, 0, 'h80, 2);
        @(negedge clk);
        cfg_wr = 2'b01;
        @(negedge clk);
        cfg_wr = 2'b00;
        apply("cnt2_first", st80, '0);
        st80.flush = 2'b01;
        apply("cnt2_flush", st80, '0);
        st80.flush = 2'b00;
        st80.dma = 1'b1;
        apply("cnt2_dma", st80, '0);
        st80.dma = 1'b0;
        st80.em = 4'b1000;
        apply("cnt2_fire", st80, 'h08);
        chk("status_set_wins", hit_status[3], 1);
        apply("clr_bit3", idle, 'h08);
        chk("status_bit3_clr", hit_status[3], 0);

        // asynchronous reset while a match is showing
        @(negedge clk);
        drive(mk(1, 0, 1, 0, 0, 0, 2, 'h40, 5, 0, 0, 'b0011, 0));
        @(negedge clk);
        #1;
        chk("pre_rst_match", match_dc4, 'b0011);
        rst = 1'b1;
        #1;
        chk("rst_match", match_dc4, 0);
        chk("rst_tid", match_tid_dc4, 0);
        chk("rst_status", hit_status, 0);
        dc3_bus.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst", mk(1, 0, 1, 0, 0, 0, 2, 'h40, 5, 0, 0, 'b0011, 0), '0);
        chk("post_rst_status", hit_status, 'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
